gray_seq_checker: RTL
=====================

Name: gray_seq_checker

Overview:
- Downstream consumer of the 3-bit Gray counter. Samples the counter's Gray output and Overflow flag every cycle.
- Converts the Gray value to binary and confirms each step is the legal successor, given the enable seen by the counter.
- Counts completed laps and latches protocol faults.
- Shares Clk, Reset and En with the counter, so both leave reset on the same edge.

Parameters:
- WIDTH, 3: Gray/binary code width.
- LAP_W, 8: width of the saturating lap counter.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset, shared with the counter.
- En  in  1  the same enable the counter sees; a 1 at edge t means the counter advances at edge t.
- Gray_in  in  WIDTH  counter output.
- Overflow_in  in  1  counter overflow flag; sticky in the producer.
- Bin_out  out  WIDTH  registered binary equivalent of Gray_in.
- Lap_count  out  LAP_W  number of max->0 wraps seen while tracking; saturates at all-ones.
- Locked  out  1  1 while in TRACK.
- Err  out  1  one-cycle pulse on the first detected violation.
- Err_sticky  out  1  set with Err; cleared only by Reset.

Behaviour:
- Reset (sampled high at an edge): state=SYNC; Bin_out=0, Lap_count=0, Locked=0, Err=0, Err_sticky=0; internal prev=0, en_d=0, ovf_seen=0. Reset wins over every other event, in any state.
- Every non-reset edge:
  - Bin_out <= gray2bin(Gray_in), giving one-cycle latency.
  - en_d <= En.
  - Err defaults to 0.
- SYNC (first non-reset edge):
  - If Gray_in==0 and Overflow_in==0: prev<=0, go to TRACK, Locked=1 from the next cycle.
  - Otherwise: Err=1, Err_sticky=1, go to FAULT.
- TRACK, at each edge:
  - Compute b=gray2bin(Gray_in), expected = en_d ? prev+1 (mod 2^WIDTH) : prev.
  - wrap = en_d && prev==2^WIDTH-1.
  - Expected overflow = ovf_seen || wrap.
  - If b==expected and Overflow_in==expected overflow: prev<=b; on wrap, ovf_seen<=1 and Lap_count<=Lap_count+1, held at all-ones if already saturated.
  - Otherwise: Err=1, Err_sticky=1, Locked<=0, go to FAULT. prev and Lap_count are not updated on the faulting edge.
  - Violations covered: a skipped or backward code, a multi-bit Gray change, a change while En was low, Overflow_in high before the first wrap, and Overflow_in dropping after the first wrap.
- FAULT: absorbing state.
  - Bin_out keeps converting; Lap_count is frozen; Locked=0; no further Err pulses.
  - Exit only via Reset, which returns to SYNC.
- Simultaneous wrap and saturation: Lap_count stays at all-ones and no error is raised.
- En toggling every cycle is legal; each comparison uses only the enable registered one edge earlier.
- Reset in the middle of TRACK or FAULT clears everything, and re-lock proceeds from SYNC.
- Out-of-range arithmetic: prev+1 is computed at WIDTH bits and truncated, so wrap is implicit.
- State encoding: 2 bits, SYNC=0, TRACK=1, FAULT=2. Code 3 is unreachable and decodes to FAULT.

Decomposition:
- Shared package/include holds:
  - State localparams SYNC/TRACK/FAULT.
  - Default WIDTH=3, shared with the counter so both ends agree.
  - Constant GRAY_MAX = 2^WIDTH-1.
- One sub-module: gray2bin, a combinational WIDTH-generic Gray-to-binary converter (b[i] = ^g[WIDTH-1:i]). It is instantiated once; the counter's tests may reuse it.

Test Plan:
- Reset 2 cycles, release with En=1 for 8 cycles, driving the counter sequence 000,001,011,010,110,111,101,100 -> Bin_out 0..7 with one-cycle lag, Locked=1, Err=0, Lap_count=0.
- Continue: 100->000 with Overflow_in rising on that edge, run 24 steps total -> Lap_count=3, Overflow_in held 1 accepted, Err=0.
- Hold En=0 for 3 cycles at Gray 011 -> Bin_out stays 2, no error; then Gray changes to 010 while en_d=0 -> Err pulse 1 cycle, Err_sticky=1, Locked=0.
- In TRACK, drive 001 then 010 (skipped 011) -> Err at that edge, FAULT; a further legal sequence keeps Lap_count frozen and Err low.
- Overflow_in=1 while at 011 before any wrap -> Err=1. Separately, Overflow_in falling to 0 after the first wrap -> Err=1.
- Reset asserted in FAULT -> all outputs 0 next cycle, re-lock on Gray 000. With LAP_W=2, 5 wraps -> Lap_count=3 with no error.

Source files
------------

// File: rtl/gray_seq_checker_pkg.sv
// Shared definitions for the 3-bit Gray counter and its downstream sequence checker.
// The default code width lives here so that producer and consumer agree on it.
package gray_seq_checker_pkg;

  localparam int GRAY_WIDTH = 3;
  localparam int GRAY_MAX   = (1 << GRAY_WIDTH) - 1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/gray_seq_checker_gray2bin.sv
// Combinational, width-generic Gray-to-binary converter: each binary bit is the
// XOR of all Gray bits at and above its position.
module gray_seq_checker_gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Checks that a Gray counter steps legally given its enable, counts completed laps
// and latches the first protocol violation until reset.
module gray_seq_checker
  import gray_seq_checker_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray_in,
  input  logic             Overflow_in,
  output logic [WIDTH-1:0] Bin_out,
  output logic [LAP_W-1:0] Lap_count,
  output logic             Locked,
  output logic             Err,
  output logic             Err_sticky
);

  localparam logic [WIDTH-1:0] L_CODE_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] L_CODE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAP_W-1:0] L_LAP_MAX  = {LAP_W{1'b1}};
  localparam logic [LAP_W-1:0] L_LAP_ONE  = {{(LAP_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_prev;
  logic [LAP_W-1:0] r_lap;
  logic             r_en_d;
  logic             r_ovf_seen;
  logic             r_locked;
  logic             r_err;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_exp_bin;
  logic             w_wrap;
  logic             w_exp_ovf;
  logic             w_step_ok;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [LAP_W-1:0] w_lap_nxt;
  logic             w_ovf_nxt;
  logic             w_err_nxt;

  gray_seq_checker_gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (Gray_in),
    .o_bin  (w_bin)
  );

  // The expectation uses only the enable registered one edge earlier; the +1 truncates at WIDTH bits.
  assign w_exp_bin = r_en_d ? (r_prev + L_CODE_ONE) : r_prev;
  assign w_wrap    = r_en_d && (r_prev == L_CODE_MAX);
  assign w_exp_ovf = r_ovf_seen || w_wrap;
  assign w_step_ok = (w_bin == w_exp_bin) && (Overflow_in == w_exp_ovf);

  // Next-state, tracking and lap-count logic.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_lap_nxt   = r_lap;
    w_ovf_nxt   = r_ovf_seen;
    w_err_nxt   = 1'b0;
    case (r_state)
      SYNC: begin
        if ((Gray_in == {WIDTH{1'b0}}) && !Overflow_in) begin
          w_state_nxt = TRACK;
          w_prev_nxt  = {WIDTH{1'b0}};
        end else begin
          w_state_nxt = FAULT;
          w_err_nxt   = 1'b1;
        end
      end
      TRACK: begin
        if (w_step_ok) begin
          w_prev_nxt = w_bin;
          if (w_wrap) begin
            w_ovf_nxt = 1'b1;
            if (r_lap != L_LAP_MAX) begin
              w_lap_nxt = r_lap + L_LAP_ONE;
            end else begin
              w_lap_nxt = r_lap;
            end
          end else begin
            w_ovf_nxt = r_ovf_seen;
          end
        end else begin
          w_state_nxt = FAULT;
          w_err_nxt   = 1'b1;
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = FAULT;
      end
    endcase
  end

  // State and output registers; reset overrides every other event.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= SYNC;
      r_bin        <= {WIDTH{1'b0}};
      r_prev       <= {WIDTH{1'b0}};
      r_lap        <= {LAP_W{1'b0}};
      r_en_d       <= 1'b0;
      r_ovf_seen   <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bin        <= w_bin;
      r_prev       <= w_prev_nxt;
      r_lap        <= w_lap_nxt;
      r_en_d       <= En;
      r_ovf_seen   <= w_ovf_nxt;
      r_locked     <= (w_state_nxt == TRACK);
      r_err        <= w_err_nxt;
      r_err_sticky <= r_err_sticky | w_err_nxt;
    end
  end

  assign Bin_out    = r_bin;
  assign Lap_count  = r_lap;
  assign Locked     = r_locked;
  assign Err        = r_err;
  assign Err_sticky = r_err_sticky;

endmodule
